// File: rtl/xy_plotter_pkg.sv
// Shared types and helpers for the XY move sequencer.
// The optional limit-stop feature is enabled by XY_LIMIT_STOP_EN.
package xy_plotter_pkg;

  localparam int STEP_W_DEF   = 16;
  localparam int PERIOD_W_DEF = 32;
  localparam int HELPER_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  // Magnitude of a sign-extended delta; the most negative value maps to its positive magnitude.
  function automatic logic [HELPER_W-1:0] abs_mag(input logic signed [HELPER_W-1:0] v);
    logic [HELPER_W-1:0] r;
    r = v[HELPER_W-1] ? -v : v;
    return r;
  endfunction

  function automatic logic [HELPER_W-1:0] max_u(input logic [HELPER_W-1:0] a,
                                                input logic [HELPER_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/xy_step_timer.sv
// Major-axis step period counter: ticks once every max(period,1) enabled cycles.
module xy_step_timer #(
  parameter int PERIOD_W = 32
) (
  input  logic                fab_clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] last_cnt;

  always_comb begin
    last_cnt = (period == '0) ? '0 : period - PERIOD_W'(1);
    tick     = enable && (cnt_q == last_cnt);
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge fab_clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xy_move_sequencer.sv
// Bresenham XY move sequencer with a one-deep command slot and absolute position tracking.
// Define XY_LIMIT_STOP_EN to add positive-end limit inputs lim_x/lim_y and a sticky fault output.
module xy_move_sequencer
  import xy_plotter_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                     fab_clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [STEP_W-1:0] cmd_dx,
  input  logic signed [STEP_W-1:0] cmd_dy,
  input  logic [PERIOD_W-1:0]      cmd_period,
  input  logic                     abort,
`ifdef XY_LIMIT_STOP_EN
  input  logic                     lim_x,
  input  logic                     lim_y,
  output logic                     fault,
`endif
  output logic                     step_x,
  output logic                     step_y,
  output logic                     dir_x,
  output logic                     dir_y,
  output logic                     busy,
  output logic                     done,
  output logic signed [STEP_W-1:0] pos_x,
  output logic signed [STEP_W-1:0] pos_y,
  output logic [STEP_W-1:0]        steps_left
);

  seq_state_e state_q, state_d;

  logic                     pend_valid_q, pend_valid_d;
  logic signed [STEP_W-1:0] pend_dx_q, pend_dx_d;
  logic signed [STEP_W-1:0] pend_dy_q, pend_dy_d;
  logic [PERIOD_W-1:0]      pend_period_q, pend_period_d;
  logic [PERIOD_W-1:0]      period_q, period_d;
  logic [STEP_W-1:0]        major_q, major_d;
  logic [STEP_W-1:0]        minor_q, minor_d;
  logic                     x_major_q, x_major_d;
  logic signed [STEP_W:0]   err_q, err_d;
  logic [STEP_W-1:0]        steps_left_q, steps_left_d;
  logic                     dir_x_q, dir_x_d;
  logic                     dir_y_q, dir_y_d;
  logic                     step_x_q, step_x_d;
  logic                     step_y_q, step_y_d;
  logic signed [STEP_W-1:0] pos_x_q, pos_x_d;
  logic signed [STEP_W-1:0] pos_y_q, pos_y_d;
`ifdef XY_LIMIT_STOP_EN
  logic                     fault_q, fault_d;
  logic                     lim_hit;
`endif

  logic                   tick;
  logic                   accept;
  logic                   kill;
  logic                   maj_fire;
  logic                   min_fire;
  logic                   x_fire;
  logic                   y_fire;
  logic signed [STEP_W:0] err_sub;
  logic signed [STEP_W:0] err_add;
  logic [STEP_W-1:0]      mag_x;
  logic [STEP_W-1:0]      mag_y;
  logic [STEP_W-1:0]      load_major;
  logic                   load_x_major;

  xy_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .fab_clk (fab_clk),
    .reset   (reset),
    .clear   (state_q != ST_RUN),
    .enable  (state_q == ST_RUN),
    .period  (period_q),
    .tick    (tick)
  );

  // Strobe decisions for this cycle; a limit hit kills the move exactly like abort.
  always_comb begin
    err_sub  = err_q - $signed({1'b0, minor_q});
    err_add  = err_sub + $signed({1'b0, major_q});
    maj_fire = (state_q == ST_RUN) && tick && (steps_left_q != '0);
    min_fire = maj_fire && err_sub[STEP_W];
    x_fire   = x_major_q ? maj_fire : min_fire;
    y_fire   = x_major_q ? min_fire : maj_fire;
`ifdef XY_LIMIT_STOP_EN
    lim_hit  = (x_fire && dir_x_q && lim_x) || (y_fire && dir_y_q && lim_y);
    kill     = abort || lim_hit;
`else
    kill     = abort;
`endif
    cmd_ready = !pend_valid_q && !kill;
    accept    = cmd_valid && cmd_ready;

    mag_x        = STEP_W'(abs_mag(HELPER_W'(pend_dx_q)));
    mag_y        = STEP_W'(abs_mag(HELPER_W'(pend_dy_q)));
    load_major   = STEP_W'(max_u(HELPER_W'(mag_x), HELPER_W'(mag_y)));
    load_x_major = (mag_x >= mag_y);
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_dx_d     = pend_dx_q;
    pend_dy_d     = pend_dy_q;
    pend_period_d = pend_period_q;
    period_d      = period_q;
    major_d       = major_q;
    minor_d       = minor_q;
    x_major_d     = x_major_q;
    err_d         = err_q;
    steps_left_d  = steps_left_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    step_x_d      = 1'b0;
    step_y_d      = 1'b0;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
`ifdef XY_LIMIT_STOP_EN
    fault_d       = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        major_d      = load_major;
        minor_d      = load_x_major ? mag_y : mag_x;
        x_major_d    = load_x_major;
        err_d        = $signed({1'b0, load_major >> 1});
        steps_left_d = load_major;
        dir_x_d      = ~pend_dx_q[STEP_W-1];
        dir_y_d      = ~pend_dy_q[STEP_W-1];
        period_d     = pend_period_q;
        pend_valid_d = 1'b0;
        state_d      = (load_major == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (maj_fire) begin
          steps_left_d = steps_left_q - STEP_W'(1);
          err_d        = min_fire ? err_add : err_sub;
          step_x_d     = x_fire;
          step_y_d     = y_fire;
          if (x_fire) pos_x_d = pos_x_q + (dir_x_q ? STEP_W'(1) : '1);
          if (y_fire) pos_y_d = pos_y_q + (dir_y_q ? STEP_W'(1) : '1);
        end
        if (steps_left_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = pend_valid_q ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      pend_valid_d  = 1'b1;
      pend_dx_d     = cmd_dx;
      pend_dy_d     = cmd_dy;
      pend_period_d = cmd_period;
`ifdef XY_LIMIT_STOP_EN
      fault_d       = 1'b0;
`endif
    end

    // Kill wins over everything, but position is deliberately kept.
    if (kill) begin
      state_d      = ST_IDLE;
      pend_valid_d = 1'b0;
      step_x_d     = 1'b0;
      step_y_d     = 1'b0;
      steps_left_d = '0;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
    end
`ifdef XY_LIMIT_STOP_EN
    if (lim_hit) fault_d = 1'b1;
`endif
  end

  always_ff @(posedge fab_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pend_valid_q  <= 1'b0;
      pend_dx_q     <= '0;
      pend_dy_q     <= '0;
      pend_period_q <= '0;
      period_q      <= '0;
      major_q       <= '0;
      minor_q       <= '0;
      x_major_q     <= 1'b0;
      err_q         <= '0;
      steps_left_q  <= '0;
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      step_x_q      <= 1'b0;
      step_y_q      <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
`ifdef XY_LIMIT_STOP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_dx_q     <= pend_dx_d;
      pend_dy_q     <= pend_dy_d;
      pend_period_q <= pend_period_d;
      period_q      <= period_d;
      major_q       <= major_d;
      minor_q       <= minor_d;
      x_major_q     <= x_major_d;
      err_q         <= err_d;
      steps_left_q  <= steps_left_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      step_x_q      <= step_x_d;
      step_y_q      <= step_y_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
`ifdef XY_LIMIT_STOP_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign step_x     = step_x_q;
  assign step_y     = step_y_q;
  assign dir_x      = dir_x_q;
  assign dir_y      = dir_y_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign steps_left = steps_left_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE) || pend_valid_q;
`ifdef XY_LIMIT_STOP_EN
  assign fault      = fault_q;
`endif

endmodule

// File: tb/tb_xy_move_sequencer.sv
// Scoreboard bench for xy_move_sequencer: each accepted move pushes its expected strobe counts,
// final position and done cycle; the monitor pops and compares on every done pulse.
module tb_xy_move_sequencer;

  localparam int STEP_W   = 16;
  localparam int PERIOD_W = 32;

  logic                     fab_clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic signed [STEP_W-1:0] cmd_dx = '0;
  logic signed [STEP_W-1:0] cmd_dy = '0;
  logic [PERIOD_W-1:0]      cmd_period = '0;
  logic                     abort = 1'b0;
  logic                     step_x, step_y, dir_x, dir_y, busy, done;
  logic signed [STEP_W-1:0] pos_x, pos_y;
  logic [STEP_W-1:0]        steps_left;
`ifdef XY_LIMIT_STOP_EN
  logic                     lim_x = 1'b0;
  logic                     lim_y = 1'b0;
  logic                     fault;
`endif

  typedef struct {
    int                       nMaj;
    int                       nMin;
    logic                     xMajor;
    logic                     dirX;
    logic                     dirY;
    logic signed [STEP_W-1:0] px;
    logic signed [STEP_W-1:0] py;
    int                       per;
    int                       acc;
    int                       mask;
  } exp_t;

  exp_t sbQ[$];

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  int doneSeen = 0;
  int expDone = 0;
  logic signed [STEP_W-1:0] modelX = '0;
  logic signed [STEP_W-1:0] modelY = '0;

  int cntMaj = 0;
  int cntMin = 0;
  int lastMaj = 0;
  int minorMask = 0;
  int prevDone = -100;

  xy_move_sequencer #(
    .STEP_W   (STEP_W),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .fab_clk    (fab_clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dx     (cmd_dx),
    .cmd_dy     (cmd_dy),
    .cmd_period (cmd_period),
    .abort      (abort),
`ifdef XY_LIMIT_STOP_EN
    .lim_x      (lim_x),
    .lim_y      (lim_y),
    .fault      (fault),
`endif
    .step_x     (step_x),
    .step_y     (step_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .busy       (busy),
    .done       (done),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .steps_left (steps_left)
  );

  always #5 fab_clk = ~fab_clk;

  always @(posedge fab_clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycleCnt);
    end
  endtask

  // Offer one command, wait (bounded) for the handshake and record what the move must produce.
  task automatic applyStimulus(input int dx, input int dy, input int per, input int mask,
                               output int waited);
    exp_t e;
    int   adx, ady;
    waited     = 0;
    cmd_dx     = STEP_W'(dx);
    cmd_dy     = STEP_W'(dy);
    cmd_period = PERIOD_W'(per);
    cmd_valid  = 1'b1;
    while (!cmd_ready && waited < 500) begin
      @(negedge fab_clk);
      waited++;
    end
    checkOutput("acceptInTime", longint'(waited < 500), 1);
    if (waited >= 500) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge fab_clk);
    #1;
    cmd_valid = 1'b0;
    adx    = (dx < 0) ? -dx : dx;
    ady    = (dy < 0) ? -dy : dy;
    modelX = modelX + STEP_W'(dx);
    modelY = modelY + STEP_W'(dy);
    e.xMajor = (adx >= ady);
    e.nMaj   = e.xMajor ? adx : ady;
    e.nMin   = e.xMajor ? ady : adx;
    e.dirX   = (dx > 0);
    e.dirY   = (dy > 0);
    e.px     = modelX;
    e.py     = modelY;
    e.per    = (per == 0) ? 1 : per;
    e.acc    = cycleCnt;
    e.mask   = mask;
    sbQ.push_back(e);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge fab_clk);
      n++;
    end
    checkOutput("idleInTime", busy, 0);
  endtask

  // Monitor: strobe bookkeeping per move, full comparison when done pulses.
  always @(negedge fab_clk) begin : monitor
    exp_t e;
    int   loadCyc, expDoneCyc;
    logic majStep, minStep;
    if (reset) begin
      if (!busy) begin
        cntMaj    = 0;
        cntMin    = 0;
        minorMask = 0;
      end
      if (step_x || step_y) begin
        if (sbQ.size() == 0) begin
          checkOutput("strayStep", 1, 0);
        end else begin
          e       = sbQ[0];
          majStep = e.xMajor ? step_x : step_y;
          minStep = e.xMajor ? step_y : step_x;
          if (step_x) checkOutput("dirX", dir_x, e.dirX);
          if (step_y) checkOutput("dirY", dir_y, e.dirY);
          if (majStep) begin
            if (cntMaj > 0) checkOutput("majorGap", cycleCnt - lastMaj, e.per);
            lastMaj = cycleCnt;
            cntMaj++;
          end
          if (minStep) begin
            cntMin++;
            if (majStep && cntMaj <= 30) minorMask = minorMask | (1 << (cntMaj - 1));
          end
        end
      end
      if (done) begin
        if (sbQ.size() == 0) begin
          checkOutput("strayDone", 1, 0);
        end else begin
          e          = sbQ.pop_front();
          loadCyc    = (e.acc + 1 > prevDone + 1) ? e.acc + 1 : prevDone + 1;
          expDoneCyc = loadCyc + ((e.nMaj == 0) ? 1 : e.nMaj * e.per + 2);
          checkOutput("majorCount", cntMaj, e.nMaj);
          checkOutput("minorCount", cntMin, e.nMin);
          checkOutput("donePosX", pos_x, e.px);
          checkOutput("donePosY", pos_y, e.py);
          checkOutput("doneCycle", cycleCnt, expDoneCyc);
          if (e.mask >= 0) checkOutput("minorSlots", minorMask, e.mask);
        end
        prevDone = cycleCnt;
        doneSeen++;
        cntMaj    = 0;
        cntMin    = 0;
        minorMask = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : main
    int w, seen, g;
    logic signed [STEP_W-1:0] startX;

    repeat (3) @(posedge fab_clk);
    @(negedge fab_clk);
    checkOutput("rstStepX", step_x, 0);
    checkOutput("rstBusy", busy, 0);
    reset = 1'b1;
    @(negedge fab_clk);
    checkOutput("rstReady", cmd_ready, 1);
    checkOutput("rstDone", done, 0);
    checkOutput("rstPosX", pos_x, 0);
    checkOutput("rstPosY", pos_y, 0);
    checkOutput("rstStepsLeft", steps_left, 0);
    checkOutput("rstDir", {dir_x, dir_y}, 0);

    $display("[TB] move (4,2) period 3");
    applyStimulus(4, 2, 3, 'b1010, w);
    expDone++;
    repeat (3) @(negedge fab_clk);
    checkOutput("t1StepsLeft", steps_left, 4);
    checkOutput("t1Busy", busy, 1);
    waitIdle(100);
    checkOutput("t1PosX", pos_x, 4);
    checkOutput("t1PosY", pos_y, 2);

    $display("[TB] move (-3,5) period 1");
    applyStimulus(-3, 5, 1, -1, w);
    expDone++;
    repeat (3) @(negedge fab_clk);
    checkOutput("t2DirX", dir_x, 0);
    checkOutput("t2DirY", dir_y, 1);
    waitIdle(100);

    $display("[TB] back-to-back moves");
    applyStimulus(3, 0, 2, -1, w);
    applyStimulus(0, -2, 1, -1, w);
    checkOutput("t3ReadyDrop", cmd_ready, 0);
    applyStimulus(1, 1, 1, -1, w);
    checkOutput("t3Stalled", longint'(w > 0), 1);
    expDone += 3;
    waitIdle(200);

    $display("[TB] zero move and period 0");
    applyStimulus(0, 0, 5, -1, w);
    waitIdle(50);
    applyStimulus(2, 1, 0, -1, w);
    waitIdle(50);
    expDone += 2;
    checkOutput("t4PosX", pos_x, modelX);

    $display("[TB] abort with pending command");
    startX = modelX;
    applyStimulus(10, 0, 2, -1, w);
    applyStimulus(5, 5, 1, -1, w);
    seen = 0;
    g    = 0;
    while (seen < 2 && g < 200) begin
      @(negedge fab_clk);
      g++;
      if (step_x) seen++;
    end
    checkOutput("t5Reached", seen, 2);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    #1;
    checkOutput("t5ReadyInAbort", cmd_ready, 0);
    @(posedge fab_clk);
    sbQ.delete();
    #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    modelX    = startX + STEP_W'(2);
    @(negedge fab_clk);
    checkOutput("t5Busy", busy, 0);
    checkOutput("t5Ready", cmd_ready, 1);
    checkOutput("t5PosX", pos_x, modelX);
    repeat (20) @(negedge fab_clk);
    checkOutput("t5StillIdle", busy, 0);

`ifdef XY_LIMIT_STOP_EN
    $display("[TB] limit stop");
    startX = modelX;
    applyStimulus(5, 0, 2, -1, w);
    g = 0;
    while (!step_x && g < 100) begin
      @(negedge fab_clk);
      g++;
    end
    lim_x = 1'b1;
    repeat (4) @(negedge fab_clk);
    sbQ.delete();
    modelX = startX + STEP_W'(1);
    checkOutput("t6Fault", fault, 1);
    checkOutput("t6Busy", busy, 0);
    checkOutput("t6PosX", pos_x, modelX);
    applyStimulus(-2, 0, 1, -1, w);
    expDone++;
    checkOutput("t6FaultClear", fault, 0);
    waitIdle(50);
    checkOutput("t6PosBack", pos_x, modelX);
    lim_x = 1'b0;
`endif

    $display("[TB] async reset mid-move");
    applyStimulus(6, 0, 3, -1, w);
    repeat (6) @(negedge fab_clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t7PosX", pos_x, 0);
    checkOutput("t7Busy", busy, 0);
    checkOutput("t7Ready", cmd_ready, 1);
    sbQ.delete();
    modelX = '0;
    modelY = '0;
    @(negedge fab_clk);
    reset = 1'b1;
    applyStimulus(1, -1, 1, -1, w);
    expDone++;
    waitIdle(50);
    checkOutput("t7PosY", pos_y, -1);

    repeat (3) @(negedge fab_clk);
    checkOutput("doneCount", doneSeen, expDone);
    checkOutput("scoreboardEmpty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
